// File: rtl/alu_muldiv_seq_if.sv
// Command, result and external-ALU signal bundle for the iterative mul/div unit.
// slave = the mul/div unit itself; master = control unit plus the combinational ALU.
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_zero;

  modport slave (
    input  start, op, in_a, in_b, alu_out, alu_zero,
    output busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_sel
  );

  modport master (
    output start, op, in_a, in_b, alu_out, alu_zero,
    input  busy, done, div_by_zero, hi, lo, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative 32-bit unsigned multiply/divide producing hi/lo, one external ALU
// add/sub per cycle; carry and borrow are rebuilt locally from operand/result MSBs.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_muldiv_seq_if.slave   bus
);

  localparam int              CW      = $clog2(ITER);
  localparam logic [CW-1:0]   LAST    = CW'(ITER - 1);
  localparam logic [2:0]      SEL_ADD = 3'b100;
  localparam logic [2:0]      SEL_SUB = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic             is_div;
  logic [WIDTH-1:0] operand;   // multiplicand or divisor, fixed for the whole operation
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] b_c;
  logic [2:0]       sel_c;
  logic             a31;
  logic             b31;
  logic             o31;
  logic             carry;
  logic             ge;

  assign rs = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};

  always_comb begin
    a_c   = '0;
    b_c   = '0;
    sel_c = SEL_ADD;
    if (state == RUN) begin
      if (is_div) begin
        a_c   = rs;
        b_c   = operand;
        sel_c = SEL_SUB;
      end else begin
        a_c   = hi_r;
        b_c   = lo_r[0] ? operand : '0;
        sel_c = SEL_ADD;
      end
    end
  end

  // The ALU exposes no flags: carry-out of a+b and no-borrow of a-b come from MSBs.
  assign a31   = a_c[WIDTH-1];
  assign b31   = b_c[WIDTH-1];
  assign o31   = bus.alu_out[WIDTH-1];
  assign carry = (a31 & b31) | ((a31 | b31) & ~o31);
  assign ge    = hi_r[WIDTH-1] | (a31 & ~b31) | (~(a31 ^ b31) & ~o31);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      is_div  <= 1'b0;
      operand <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state   <= RUN;
            busy_r  <= 1'b1;
            is_div  <= bus.op;
            operand <= bus.op ? bus.in_b : bus.in_a;
            hi_r    <= '0;
            lo_r    <= bus.op ? bus.in_a : bus.in_b;
            count   <= '0;
            dbz_r   <= bus.op & (bus.in_b == '0);
          end
        end
        RUN: begin
          if (is_div) begin
            if (ge) begin
              hi_r <= bus.alu_out;
              lo_r <= {lo_r[WIDTH-2:0], 1'b1};
            end else begin
              hi_r <= rs;
              lo_r <= {lo_r[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi_r <= {carry, bus.alu_out[WIDTH-1:1]};
            lo_r <= {bus.alu_out[0], lo_r[WIDTH-1:1]};
          end
          count <= count + CW'(1);
          if (count == LAST) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_a       = a_c;
  assign bus.alu_b       = b_c;
  assign bus.alu_sel     = sel_c;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench: directed vector table, ignored-start and async-reset
// sequences, then random operations against a plain-arithmetic reference.
module tb_alu_muldiv_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_muldiv_seq_if #(.WIDTH(32)) bus ();

  alu_muldiv_seq #(.WIDTH(32), .ITER(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational external ALU.
  always_comb begin
    case (bus.alu_sel)
      3'b000:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b101:  bus.alu_out = bus.alu_a + ~bus.alu_b + 32'd1;
      3'b110,
      3'b111:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_out == 32'd0);
  end

  typedef struct {
    string       name;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic opv, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic dz);
    logic [63:0] p;
    if (!opv) begin
      p  = {32'd0, a} * {32'd0, b};
      h  = p[63:32];
      l  = p[31:0];
      dz = 1'b0;
    end else if (b == 32'd0) begin
      h  = a;
      l  = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else begin
      h  = a % b;
      l  = a / b;
      dz = 1'b0;
    end
  endfunction

  // One operation; optionally pulses start mid-RUN (pulse_run = cycle index) and in DONE.
  task automatic do_op(input string name, input logic opv, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic exp_dz,
                       input int pulse_run, input bit pulse_done);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = opv;
    bus.in_a  = a;
    bus.in_b  = b;
    @(negedge clk);
    bus.start = 1'b0;
    cyc       = 1;
    busy_cnt  = 0;
    check({name, " alu_sel first"}, 64'(bus.alu_sel), opv ? 64'h5 : 64'h4);
    while (!bus.done && cyc < 100) begin
      if (bus.busy) busy_cnt++;
      bus.in_a = $urandom;
      bus.in_b = $urandom;
      if (cyc == pulse_run) begin
        bus.start = 1'b1;
        bus.op    = ~opv;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (cyc >= 100) begin
      check({name, " done timeout"}, 64'(cyc), 64'd33);
    end else begin
      check({name, " latency"}, 64'(cyc), 64'd33);
      check({name, " busy cycles"}, 64'(busy_cnt), 64'd32);
      check({name, " busy at done"}, 64'(bus.busy), 64'd0);
      check({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
      check({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
      check({name, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dz));
      if (pulse_done) begin
        bus.start = 1'b1;
        bus.op    = ~opv;
      end
      @(negedge clk);
      bus.start = 1'b0;
      check({name, " done pulse width"}, 64'(bus.done), 64'd0);
      check({name, " idle alu"}, {bus.alu_a, bus.alu_b[28:0], bus.alu_sel}, {61'd0, 3'b100});
      if (pulse_done) begin
        repeat (3) begin
          @(negedge clk);
          check({name, " no restart"}, {62'(bus.busy), bus.done}, 64'd0);
        end
        check({name, " hi hold"}, 64'(bus.hi), 64'(exp_hi));
        check({name, " lo hold"}, 64'(bus.lo), 64'(exp_lo));
      end
    end
  endtask

  initial begin
    logic [31:0] mh;
    logic [31:0] ml;
    logic        mdz;
    logic        rop;
    logic [31:0] ra;
    logic [31:0] rb;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.in_a  = 32'd0;
    bus.in_b  = 32'd0;

    vecs[0] = '{"mul 7x6",     1'b0, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0};
    vecs[1] = '{"mul max",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2] = '{"div 100/7",   1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3] = '{"div max/1",   1'b1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[4] = '{"div 5/9",     1'b1, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0};
    vecs[5] = '{"div 1234/0",  1'b1, 32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF, 1'b1};
    vecs[6] = '{"mul 3x3",     1'b0, 32'd3,        32'd3,        32'd0,        32'd9,        1'b0};

    repeat (3) @(negedge clk);
    check("reset outputs", {59'd0, bus.busy, bus.done, bus.div_by_zero, 2'b00}, 64'd0);
    check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    check("reset alu", {bus.alu_a, bus.alu_b[28:0], bus.alu_sel}, {61'd0, 3'b100});
    rst = 1'b0;
    @(negedge clk);
    check("idle after reset", {62'd0, bus.busy, bus.done}, 64'd0);

    for (int i = 0; i < 7; i++)
      do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz, 0, 1'b0);

    // Start pulses in RUN and in DONE must be ignored.
    do_op("ignored starts", 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 5, 1'b1);

    // Asynchronous reset partway through a multiply.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.in_a  = 32'h0001_2345;
    bus.in_b  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy before abort", 64'(bus.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("abort flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
    check("abort hi/lo", {bus.hi, bus.lo}, 64'd0);
    check("abort alu_sel", 64'(bus.alu_sel), 64'h4);
    @(negedge clk);
    rst = 1'b0;
    do_op("mul 2x3 after abort", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 1'($urandom_range(0, 1));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (i % 2 == 1) ra = ra >> $urandom_range(0, 31);
      model(rop, ra, rb, mh, ml, mdz);
      do_op(rop ? "rand div" : "rand mul", rop, ra, rb, mh, ml, mdz, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
